ga_multilane_engine: RTL and testbench
======================================

# ga_multilane_engine

Steady-state genetic-algorithm engine, the parametrised successor of the single-channel GA core. It dispatches mutated offspring to `Lanes` independent external fitness evaluators, keeps the population in on-chip registers, and runs tournament selection with replace-if-better insertion. It tracks the best individual and stops on a target error or an evaluation budget. It sits between the random/crossover primitives and the application's fitness units.

## Interface
- `ErrorWidth`, 32, fitness error width; lower is better.
- `IndividualWidth`, 32, chromosome width.
- `PopulationAddressWidth`, 5, population depth = 2^PopulationAddressWidth.
- `Lanes`, 2, number of parallel fitness channels (1..8).
- `MutationAndDepth`, 2, random words ANDed to form the mutation mask (1..4); each bit flips with probability 2^-MutationAndDepth.
- `BudgetWidth`, 16, width of the evaluation counter.
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-high.
- `targetError` in ErrorWidth: stop once `bestError <= targetError`.
- `budget` in BudgetWidth: stop once `evaluations == budget`; 0 means unlimited.
- `fitnessStart` out Lanes: one-cycle pulse per lane, presents a new individual.
- `fitnessIndividual` out Lanes*IndividualWidth: per-lane individual, held stable until that lane's finish.
- `fitnessFinish` in Lanes: one-cycle pulse per lane, result valid.
- `fitnessError` in Lanes*ErrorWidth: per-lane error, sampled on finish.
- `bestIndividual` out IndividualWidth: best individual committed so far.
- `bestError` out ErrorWidth: error of `bestIndividual`.
- `evaluations` out BudgetWidth: count of committed results; saturates.
- `done` out 1: sticky stop flag.

## Operation
- Top FSM has three states: INIT, RUN, DONE.
  - INIT: writes one population slot per cycle with a random individual and error all-ones. It takes 2^PopulationAddressWidth cycles, then enters RUN.
  - RUN: generation and commit operate concurrently (see below).
  - DONE: no new starts; in-flight lanes are allowed to finish and commit; `done`=1 until `rst`.
- The generator FSM in RUN has four states: SEL_A, SEL_B, XOVER, DISPATCH.
  - SEL_A: reads two random slots and latches the lower-error one as dad. On a tie the first address wins.
  - SEL_B: does the same to pick mom, and latches a random victim address.
  - XOVER: single-point crossover at a random cut c in 0..IndividualWidth-1. Child = (dad & mask_c) | (mom & ~mask_c), where mask_c has the low c bits set. The mutation mask is then XORed in.
  - DISPATCH: waits for the lowest-indexed idle lane. That lane latches the child and victim address, goes busy, and pulses `fitnessStart`. The FSM returns to SEL_A.
- Each lane is a small FSM with states IDLE, BUSY, PENDING.
  - On `fitnessFinish` the lane captures the error and moves BUSY to PENDING.
  - A finish on an IDLE or PENDING lane is ignored.
- Commit path:
  - One PENDING lane is committed per cycle, lowest index first.
  - If the captured error is strictly less than `error[victim]`, the slot is overwritten. Otherwise the population is unchanged.
  - `evaluations` increments on every commit.
  - `best*` updates when the error is strictly less than `bestError`.
  - The lane then returns to IDLE.
- A commit write to slot v in the same cycle as a selection read of v returns the old value (read-before-write).
- Stop condition, evaluated after each commit: `bestError <= targetError` or (`budget != 0` and `evaluations == budget`). When it holds, the top FSM enters DONE the next cycle.

## Timing
- Reset values:
  - `fitnessStart`=0, `fitnessIndividual`=0, `done`=0.
  - `bestError`=all-ones, `bestIndividual`=0, `evaluations`=0.
  - All lanes IDLE; top FSM in INIT.
- First `fitnessStart` comes 2^PopulationAddressWidth + 4 cycles after `rst` deasserts.
- Steady-state issue rate is one start per 4 cycles, less if all lanes are busy.
- Finish to commit takes 1 cycle minimum, plus one cycle per lower-indexed PENDING lane ahead of it.
- `best*` and `evaluations` are visible the cycle after commit.
- Lanes finishing simultaneously are all captured in the same cycle and committed serially.
- `fitnessStart` and `fitnessFinish` on the same lane in the same cycle is illegal.
- `rst` mid-operation aborts all lanes; finishes arriving after reset on lanes that are now IDLE are dropped.

## Structure
- Shared header `ga/GaDefs.v` holds the top, generator and lane state encodings and the `lane_sel` priority function.
- Sub-module `GaLane` contains the per-lane FSM, individual/victim/error registers, and the start/finish handshake.
- Randomness is reused, not rebuilt: one `RandomicCAParitBased` instance for addresses and cut, and one sized IndividualWidth*MutationAndDepth for mutation.

## Test plan
- Reset, PopulationAddressWidth=3: `fitnessStart` stays 0 for 8 INIT cycles, then the first start arrives on lane 0 at cycle 12; `bestError`=0xFFFFFFFF.
- Lanes=2, evaluator returns error = popcount(individual) after 5 cycles: `bestError` is monotonically non-increasing and `evaluations` counts every finish.
- Both lanes finish in the same cycle with errors 3 and 7: lane 0 commits at +1 and lane 1 at +2; `bestError`=3; `evaluations`+=2.
- `targetError`=10 with an evaluator returning 9 on the first result: `done`=1 two cycles after that finish; no further starts; the other in-flight lane still commits.
- `budget`=5 with errors always 100: `done` asserts after the 5th commit and `evaluations` holds at 5.
- `rst` pulsed while both lanes are BUSY, followed by stray finishes: no commit and `evaluations`=0; INIT restarts.

Source files
------------

// File: rtl/ga_multilane_engine_pkg.sv
// rtl/ga_multilane_engine_pkg.sv - state encodings and lane priority helper for the GA engine
package ga_multilane_engine_pkg;

  localparam int MAX_LANES = 8;

  typedef enum logic [1:0] {TOP_INIT, TOP_RUN, TOP_DONE} top_state_e;
  typedef enum logic [1:0] {GEN_SEL_A, GEN_SEL_B, GEN_XOVER, GEN_DISPATCH} gen_state_e;
  typedef enum logic [1:0] {LANE_IDLE, LANE_BUSY, LANE_PENDING} lane_state_e;

  // Lowest set request bit wins; returns 0 when nothing is requested.
  function automatic logic [2:0] lane_sel(input logic [MAX_LANES-1:0] req);
    logic [2:0] sel;
    sel = 3'd0;
    for (int i = MAX_LANES - 1; i >= 0; i--) begin
      if (req[i]) sel = 3'(i);
    end
    return sel;
  endfunction

endpackage

// File: rtl/ga_multilane_engine_lane.sv
// rtl/ga_multilane_engine_lane.sv - one fitness channel: holds a child until its error is committed
module ga_multilane_engine_lane
  import ga_multilane_engine_pkg::*;
#(
  parameter int IndividualWidth = 32,
  parameter int ErrorWidth      = 32,
  parameter int AddrWidth       = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       dispatch,
  input  logic [IndividualWidth-1:0] child,
  input  logic [AddrWidth-1:0]       victim,
  input  logic                       finish,
  input  logic [ErrorWidth-1:0]      error,
  input  logic                       commit,
  output logic                       start,
  output logic [IndividualWidth-1:0] individual,
  output logic [AddrWidth-1:0]       victim_addr,
  output logic [ErrorWidth-1:0]      captured_error,
  output logic                       idle,
  output logic                       pending
);

  lane_state_e                state_q, state_d;
  logic [IndividualWidth-1:0] ind_q, ind_d;
  logic [AddrWidth-1:0]       victim_q, victim_d;
  logic [ErrorWidth-1:0]      err_q, err_d;
  logic                       start_q, start_d;

  always_comb begin
    state_d  = state_q;
    ind_d    = ind_q;
    victim_d = victim_q;
    err_d    = err_q;
    start_d  = 1'b0;
    case (state_q)
      LANE_IDLE: begin
        if (dispatch) begin
          state_d  = LANE_BUSY;
          ind_d    = child;
          victim_d = victim;
          start_d  = 1'b1;
        end
      end
      LANE_BUSY: begin
        if (finish) begin
          err_d   = error;
          state_d = LANE_PENDING;
        end
      end
      LANE_PENDING: begin
        if (commit) state_d = LANE_IDLE;
      end
      default: state_d = LANE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LANE_IDLE;
      ind_q    <= '0;
      victim_q <= '0;
      err_q    <= '0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ind_q    <= ind_d;
      victim_q <= victim_d;
      err_q    <= err_d;
      start_q  <= start_d;
    end
  end

  assign start          = start_q;
  assign individual     = ind_q;
  assign victim_addr    = victim_q;
  assign captured_error = err_q;
  assign idle           = (state_q == LANE_IDLE);
  assign pending        = (state_q == LANE_PENDING);

endmodule

// File: rtl/ga_multilane_engine_rng.sv
// rtl/ga_multilane_engine_rng.sv - free-running rule-30 cellular automaton random source
module ga_multilane_engine_rng #(
  parameter int Width = 32,
  parameter int Salt  = 0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [Width-1:0] rnd
);

  localparam logic [Width-1:0] Seed = (Width'(1) << (Width / 2)) | (Width'(1) << (Salt % Width));

  logic [Width-1:0] state_q, state_d;
  logic [Width-1:0] left_nb, right_nb;

  always_comb begin
    left_nb  = {state_q[Width-2:0], state_q[Width-1]};
    right_nb = {state_q[0], state_q[Width-1:1]};
    state_d  = left_nb ^ (state_q | right_nb);
    // The all-zero state is a fixed point; reseed instead of locking up.
    if (state_q == '0) state_d = Seed;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= Seed;
    else     state_q <= state_d;
  end

  assign rnd = state_q;

endmodule

// File: rtl/ga_multilane_engine.sv
// rtl/ga_multilane_engine.sv - steady-state GA: tournament selection, crossover/mutation,
// multi-lane fitness dispatch and replace-if-better commit
module ga_multilane_engine
  import ga_multilane_engine_pkg::*;
#(
  parameter int ErrorWidth             = 32,
  parameter int IndividualWidth        = 32,
  parameter int PopulationAddressWidth = 5,
  parameter int Lanes                  = 2,
  parameter int MutationAndDepth       = 2,
  parameter int BudgetWidth            = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ErrorWidth-1:0]            targetError,
  input  logic [BudgetWidth-1:0]           budget,
  output logic [Lanes-1:0]                 fitnessStart,
  output logic [Lanes*IndividualWidth-1:0] fitnessIndividual,
  input  logic [Lanes-1:0]                 fitnessFinish,
  input  logic [Lanes*ErrorWidth-1:0]      fitnessError,
  output logic [IndividualWidth-1:0]       bestIndividual,
  output logic [ErrorWidth-1:0]            bestError,
  output logic [BudgetWidth-1:0]           evaluations,
  output logic                             done
);

  localparam int AW           = PopulationAddressWidth;
  localparam int PopDepth     = 1 << AW;
  localparam int CutWidth     = $clog2(IndividualWidth);
  localparam int SelRndWidth  = 3 * AW + CutWidth;
  localparam int MutRndWidth  = IndividualWidth * MutationAndDepth;
  localparam int LaneIdxWidth = (Lanes > 1) ? $clog2(Lanes) : 1;

  top_state_e                 top_q, top_d;
  gen_state_e                 gen_q, gen_d;
  logic [AW-1:0]              init_addr_q, init_addr_d;
  logic [AW-1:0]              victim_q, victim_d;
  logic [IndividualWidth-1:0] dad_q, dad_d, mom_q, mom_d, child_q, child_d;
  logic [IndividualWidth-1:0] pop_ind_q [PopDepth];
  logic [IndividualWidth-1:0] pop_ind_d [PopDepth];
  logic [ErrorWidth-1:0]      pop_err_q [PopDepth];
  logic [ErrorWidth-1:0]      pop_err_d [PopDepth];
  logic [IndividualWidth-1:0] best_ind_q, best_ind_d;
  logic [ErrorWidth-1:0]      best_err_q, best_err_d;
  logic [BudgetWidth-1:0]     evals_q, evals_d;

  logic [SelRndWidth-1:0]     sel_rnd;
  logic [MutRndWidth-1:0]     mut_rnd;
  logic [AW-1:0]              rnd_a, rnd_b, rnd_v;
  logic [CutWidth-1:0]        rnd_cut, cut;
  logic [IndividualWidth-1:0] pick, cut_mask, mut_mask;

  logic [Lanes-1:0]           lane_idle, lane_pending, lane_dispatch, lane_commit;
  logic [IndividualWidth-1:0] lane_ind    [Lanes];
  logic [AW-1:0]              lane_victim [Lanes];
  logic [ErrorWidth-1:0]      lane_err    [Lanes];
  logic [LaneIdxWidth-1:0]    idle_sel, pend_sel;
  logic                       dispatch_en, commit_en, stop_hit;
  logic [IndividualWidth-1:0] commit_ind;
  logic [AW-1:0]              commit_victim;
  logic [ErrorWidth-1:0]      commit_err;

  ga_multilane_engine_rng #(.Width(SelRndWidth), .Salt(1)) u_sel_rng (
    .clk(clk), .rst(rst), .rnd(sel_rnd)
  );

  ga_multilane_engine_rng #(.Width(MutRndWidth), .Salt(7)) u_mut_rng (
    .clk(clk), .rst(rst), .rnd(mut_rnd)
  );

  assign rnd_a   = sel_rnd[AW-1:0];
  assign rnd_b   = sel_rnd[2*AW-1:AW];
  assign rnd_v   = sel_rnd[3*AW-1:2*AW];
  assign rnd_cut = sel_rnd[SelRndWidth-1:3*AW];
  assign cut     = CutWidth'(rnd_cut % IndividualWidth);

  assign cut_mask = (IndividualWidth'(1) << cut) - IndividualWidth'(1);
  // Tie goes to the first address drawn.
  assign pick = (pop_err_q[rnd_a] <= pop_err_q[rnd_b]) ? pop_ind_q[rnd_a] : pop_ind_q[rnd_b];

  always_comb begin
    mut_mask = '1;
    for (int d = 0; d < MutationAndDepth; d++) begin
      mut_mask = mut_mask & mut_rnd[d*IndividualWidth +: IndividualWidth];
    end
  end

  assign idle_sel      = LaneIdxWidth'(lane_sel(MAX_LANES'(lane_idle)));
  assign pend_sel      = LaneIdxWidth'(lane_sel(MAX_LANES'(lane_pending)));
  assign commit_en     = |lane_pending;
  assign commit_ind    = lane_ind[pend_sel];
  assign commit_victim = lane_victim[pend_sel];
  assign commit_err    = lane_err[pend_sel];
  assign lane_commit   = commit_en ? (Lanes'(1) << pend_sel) : '0;
  // A stop decided this cycle must not race a fresh start out of the door.
  assign dispatch_en   = (top_q == TOP_RUN) && (gen_q == GEN_DISPATCH) && (|lane_idle) && !stop_hit;
  assign lane_dispatch = dispatch_en ? (Lanes'(1) << idle_sel) : '0;

  always_comb begin
    best_ind_d = best_ind_q;
    best_err_d = best_err_q;
    evals_d    = evals_q;
    stop_hit   = 1'b0;
    if (commit_en) begin
      if (commit_err < best_err_q) begin
        best_err_d = commit_err;
        best_ind_d = commit_ind;
      end
      if ((evals_q != '1) && !((budget != '0) && (evals_q >= budget))) begin
        evals_d = evals_q + 1'b1;
      end
      stop_hit = (best_err_d <= targetError) || ((budget != '0) && (evals_d == budget));
    end
  end

  always_comb begin
    top_d       = top_q;
    gen_d       = gen_q;
    init_addr_d = init_addr_q;
    victim_d    = victim_q;
    dad_d       = dad_q;
    mom_d       = mom_q;
    child_d     = child_q;
    pop_ind_d   = pop_ind_q;
    pop_err_d   = pop_err_q;

    case (top_q)
      TOP_INIT: begin
        pop_ind_d[init_addr_q] = mut_rnd[IndividualWidth-1:0];
        pop_err_d[init_addr_q] = '1;
        init_addr_d            = init_addr_q + 1'b1;
        if (&init_addr_q) top_d = TOP_RUN;
      end
      TOP_RUN: begin
        if (stop_hit) top_d = TOP_DONE;
        case (gen_q)
          GEN_SEL_A: begin
            dad_d = pick;
            gen_d = GEN_SEL_B;
          end
          GEN_SEL_B: begin
            mom_d    = pick;
            victim_d = rnd_v;
            gen_d    = GEN_XOVER;
          end
          GEN_XOVER: begin
            child_d = ((dad_q & cut_mask) | (mom_q & ~cut_mask)) ^ mut_mask;
            gen_d   = GEN_DISPATCH;
          end
          GEN_DISPATCH: begin
            if (dispatch_en) gen_d = GEN_SEL_A;
          end
          default: gen_d = GEN_SEL_A;
        endcase
      end
      default: top_d = TOP_DONE;
    endcase

    if (commit_en && (commit_err < pop_err_q[commit_victim])) begin
      pop_ind_d[commit_victim] = commit_ind;
      pop_err_d[commit_victim] = commit_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      top_q       <= TOP_INIT;
      gen_q       <= GEN_SEL_A;
      init_addr_q <= '0;
      victim_q    <= '0;
      dad_q       <= '0;
      mom_q       <= '0;
      child_q     <= '0;
      best_ind_q  <= '0;
      best_err_q  <= '1;
      evals_q     <= '0;
    end else begin
      top_q       <= top_d;
      gen_q       <= gen_d;
      init_addr_q <= init_addr_d;
      victim_q    <= victim_d;
      dad_q       <= dad_d;
      mom_q       <= mom_d;
      child_q     <= child_d;
      best_ind_q  <= best_ind_d;
      best_err_q  <= best_err_d;
      evals_q     <= evals_d;
    end
  end

  // INIT rewrites every slot, so the population itself needs no reset.
  always_ff @(posedge clk) begin
    pop_ind_q <= pop_ind_d;
    pop_err_q <= pop_err_d;
  end

  for (genvar l = 0; l < Lanes; l++) begin : g_lane
    ga_multilane_engine_lane #(
      .IndividualWidth(IndividualWidth),
      .ErrorWidth     (ErrorWidth),
      .AddrWidth      (AW)
    ) u_lane (
      .clk           (clk),
      .rst           (rst),
      .dispatch      (lane_dispatch[l]),
      .child         (child_q),
      .victim        (victim_q),
      .finish        (fitnessFinish[l]),
      .error         (fitnessError[l*ErrorWidth +: ErrorWidth]),
      .commit        (lane_commit[l]),
      .start         (fitnessStart[l]),
      .individual    (lane_ind[l]),
      .victim_addr   (lane_victim[l]),
      .captured_error(lane_err[l]),
      .idle          (lane_idle[l]),
      .pending       (lane_pending[l])
    );
    assign fitnessIndividual[l*IndividualWidth +: IndividualWidth] = lane_ind[l];
  end

  assign bestIndividual = best_ind_q;
  assign bestError      = best_err_q;
  assign evaluations    = evals_q;
  assign done           = (top_q == TOP_DONE);

endmodule

// File: tb/tb_ga_multilane_engine.sv
// tb/tb_ga_multilane_engine.sv - directed self-checking bench for ga_multilane_engine
module tb_ga_multilane_engine;

  localparam int EW  = 32;
  localparam int IW  = 32;
  localparam int PAW = 3;
  localparam int L   = 2;
  localparam int BW  = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [EW-1:0]   targetError;
  logic [BW-1:0]   budget;
  logic [L-1:0]    fitnessStart;
  logic [L*IW-1:0] fitnessIndividual;
  logic [L-1:0]    fitnessFinish;
  logic [L*EW-1:0] fitnessError;
  logic [IW-1:0]   bestIndividual;
  logic [EW-1:0]   bestError;
  logic [BW-1:0]   evaluations;
  logic            done;

  int checks   = 0;
  int failures = 0;

  int            cnt [L];
  logic [IW-1:0] ind_m [L];
  logic [EW-1:0] err_m [L];
  int            nfin, nonmono, starts_after_done, early;
  logic [EW-1:0] model_best, prev_best;

  always #5 clk = ~clk;

  ga_multilane_engine #(
    .ErrorWidth(EW), .IndividualWidth(IW), .PopulationAddressWidth(PAW),
    .Lanes(L), .MutationAndDepth(2), .BudgetWidth(BW)
  ) dut (
    .clk(clk), .rst(rst), .targetError(targetError), .budget(budget),
    .fitnessStart(fitnessStart), .fitnessIndividual(fitnessIndividual),
    .fitnessFinish(fitnessFinish), .fitnessError(fitnessError),
    .bestIndividual(bestIndividual), .bestError(bestError),
    .evaluations(evaluations), .done(done)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    rst           = 1'b1;
    fitnessFinish = '0;
    fitnessError  = '0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    for (int l = 0; l < L; l++) cnt[l] = 0;
  endtask

  // Called on the negedge where rst was just released; ends 16 cycles later with both lanes busy.
  task automatic await_starts(input string tag);
    int quiet_errs;
    quiet_errs = 0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (n == 12) begin
        check_eq({tag, "_start_lane0"}, 64'(fitnessStart), 64'd1);
        ind_m[0] = fitnessIndividual[IW-1:0];
      end else if (n == 16) begin
        check_eq({tag, "_start_lane1"}, 64'(fitnessStart), 64'd2);
        ind_m[1] = fitnessIndividual[2*IW-1:IW];
      end else if (fitnessStart != '0) begin
        quiet_errs++;
      end
    end
    check_eq({tag, "_no_early_start"}, 64'(quiet_errs), 64'd0);
  endtask

  task automatic run_eval(input int cycles, input int accept_until, input logic [EW-1:0] fixed_err,
                          input bit use_pop);
    logic [L-1:0]  fin;
    logic [EW-1:0] e;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      fin = '0;
      if (bestError > prev_best) nonmono++;
      prev_best = bestError;
      for (int l = 0; l < L; l++) begin
        if (cnt[l] > 0) begin
          cnt[l]--;
          if (cnt[l] == 0) begin
            e        = use_pop ? EW'($countones(ind_m[l])) : fixed_err;
            err_m[l] = e;
            fin[l]   = 1'b1;
            nfin++;
            if (e < model_best) model_best = e;
          end
        end
        if (fitnessStart[l]) begin
          if (done) starts_after_done++;
          if (c < accept_until) begin
            ind_m[l] = fitnessIndividual[l*IW +: IW];
            cnt[l]   = 5;
          end
        end
      end
      fitnessFinish = fin;
      fitnessError  = {err_m[1], err_m[0]};
    end
    @(negedge clk);
    fitnessFinish = '0;
  endtask

  task automatic clear_model();
    model_best        = '1;
    prev_best         = '1;
    nfin              = 0;
    nonmono           = 0;
    starts_after_done = 0;
  endtask

  initial begin
    rst           = 1'b1;
    targetError   = '0;
    budget        = '0;
    fitnessFinish = '0;
    fitnessError  = '0;
    for (int l = 0; l < L; l++) begin
      cnt[l]   = 0;
      err_m[l] = '0;
      ind_m[l] = '0;
    end

    // Reset values and INIT-to-first-start latency.
    repeat (3) @(negedge clk);
    check_eq("rst_start", 64'(fitnessStart), 64'd0);
    check_eq("rst_indiv", 64'(fitnessIndividual), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_best_err", 64'(bestError), 64'hFFFF_FFFF);
    check_eq("rst_best_ind", 64'(bestIndividual), 64'd0);
    check_eq("rst_evals", 64'(evaluations), 64'd0);
    rst = 1'b0;
    await_starts("init");

    // Simultaneous finishes commit serially, lowest lane first.
    @(negedge clk);
    check_eq("sim_hold_lane0", 64'(fitnessIndividual[IW-1:0]), 64'(ind_m[0]));
    fitnessFinish = 2'b11;
    fitnessError  = {32'd7, 32'd3};
    @(negedge clk);
    fitnessFinish = '0;
    check_eq("sim_evals_captured", 64'(evaluations), 64'd0);
    @(negedge clk);
    check_eq("sim_evals_p1", 64'(evaluations), 64'd1);
    check_eq("sim_best_p1", 64'(bestError), 64'd3);
    check_eq("sim_bind_p1", 64'(bestIndividual), 64'(ind_m[0]));
    @(negedge clk);
    check_eq("sim_evals_p2", 64'(evaluations), 64'd2);
    check_eq("sim_best_p2", 64'(bestError), 64'd3);
    check_eq("sim_bind_p2", 64'(bestIndividual), 64'(ind_m[0]));

    // Popcount evaluator with 5-cycle latency.
    targetError = '0;
    budget      = '0;
    apply_reset(2);
    clear_model();
    run_eval(180, 150, '0, 1'b1);
    check_eq("pop_monotonic", 64'(nonmono), 64'd0);
    check_eq("pop_evals", 64'(evaluations), 64'(nfin));
    check_eq("pop_best", 64'(bestError), 64'(model_best));

    // Target error reached on the first result.
    targetError = 32'd10;
    apply_reset(2);
    await_starts("tgt");
    @(negedge clk);
    check_eq("tgt_hold_lane0", 64'(fitnessIndividual[IW-1:0]), 64'(ind_m[0]));
    fitnessFinish = 2'b01;
    fitnessError  = {32'd0, 32'd9};
    @(negedge clk);
    fitnessFinish = '0;
    check_eq("tgt_done_early", 64'(done), 64'd0);
    @(negedge clk);
    check_eq("tgt_done", 64'(done), 64'd1);
    check_eq("tgt_best", 64'(bestError), 64'd9);
    check_eq("tgt_evals1", 64'(evaluations), 64'd1);
    early = 0;
    repeat (8) begin
      @(negedge clk);
      if (fitnessStart != '0) early++;
    end
    check_eq("tgt_no_starts", 64'(early), 64'd0);
    fitnessFinish = 2'b10;
    fitnessError  = {32'd50, 32'd0};
    @(negedge clk);
    fitnessFinish = '0;
    @(negedge clk);
    check_eq("tgt_evals2", 64'(evaluations), 64'd2);
    check_eq("tgt_done_sticky", 64'(done), 64'd1);
    check_eq("tgt_best_kept", 64'(bestError), 64'd9);

    // Evaluation budget of 5 with constant error 100.
    targetError = '0;
    budget      = 16'd5;
    apply_reset(2);
    clear_model();
    run_eval(150, 150, 32'd100, 1'b0);
    check_eq("bud_done", 64'(done), 64'd1);
    check_eq("bud_evals", 64'(evaluations), 64'd5);
    check_eq("bud_best", 64'(bestError), 64'd100);
    check_eq("bud_no_start_after_done", 64'(starts_after_done), 64'd0);

    // Reset with both lanes busy, then stray finishes.
    budget = '0;
    apply_reset(2);
    await_starts("abort");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst           = 1'b0;
    fitnessFinish = 2'b11;
    fitnessError  = {32'd1, 32'd1};
    early         = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      fitnessFinish = '0;
      if (n == 4) begin
        check_eq("abort_evals", 64'(evaluations), 64'd0);
        check_eq("abort_best", 64'(bestError), 64'hFFFF_FFFF);
        check_eq("abort_done", 64'(done), 64'd0);
      end
      if (n < 12 && fitnessStart != '0) early++;
    end
    check_eq("abort_no_early_start", 64'(early), 64'd0);
    check_eq("abort_restart_lane0", 64'(fitnessStart), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
